adder4b_reg: RTL and testbench

Registered unsigned adder with clock enable and full-width carry-preserving sum. The block samples two WIDTH-bit operands and registers their WIDTH+1-bit sum, plus status flags, on a clock edge. It serves as a pipelined arithmetic leaf in datapaths needing a held, glitch-free sum. Default configuration is a 4-bit adder with a 5-bit result.

---
 rtl/adder4b_reg.sv | 84 ++++++++
 tb/tb_adder4b_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adder4b_reg.sv
// Registered unsigned adder: WIDTH-bit operands, WIDTH+1-bit carry-preserving sum plus flags.
// Latency: 1 clock (2 clocks when ADDER_IN_REG_EN is defined); throughput 1 sum per cycle.
// Backpressure: none; enable=0 holds Sum/carry/zero/s_ovf and drops sum_valid.
//
// Optional build macro: ADDER_IN_REG_EN adds an input register stage on A, B and enable.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   enable     1 = load new sum on this edge, 0 = hold
//   A, B       unsigned WIDTH-bit operands
//   Sum        registered A+B, WIDTH+1 bits, MSB is carry-out
//   sum_valid  1 for one cycle after each enabled update
//   carry      registered copy of Sum[WIDTH]
//   zero       1 when registered Sum == 0
//   s_ovf      signed overflow of A+B viewed as two's-complement WIDTH-bit values
module adder4b_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   Sum,
  output logic             sum_valid,
  output logic             carry,
  output logic             zero,
  output logic             s_ovf
);

  // Operands and enable as seen by the sum/flag stage.
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             en_s;

`ifdef ADDER_IN_REG_EN
  // Input stage loads unconditionally every edge; enable is delayed with the
  // operands so sum_valid lines up with the data it qualifies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_s  <= '0;
      b_s  <= '0;
      en_s <= 1'b0;
    end else begin
      a_s  <= A;
      b_s  <= B;
      en_s <= enable;
    end
  end
`else
  assign a_s  = A;
  assign b_s  = B;
  assign en_s = enable;
`endif

  logic [WIDTH:0] sum_d;
  logic           ovf_d;

  // Zero-extend both operands so the carry lands in bit WIDTH.
  assign sum_d = {1'b0, a_s} + {1'b0, b_s};

  // Signed overflow: like-signed operands producing a result of the other sign.
  assign ovf_d = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_d[WIDTH-1] != a_s[WIDTH-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Sum       <= '0;
      sum_valid <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      s_ovf     <= 1'b0;
    end else begin
      sum_valid <= en_s;
      if (en_s) begin
        Sum   <= sum_d;
        carry <= sum_d[WIDTH];
        zero  <= (sum_d == '0);
        s_ovf <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_adder4b_reg.sv
// Self-checking bench for adder4b_reg: directed cases then randomized traffic vs. a reference model.
// Latency: model follows 1 clock, or 2 clocks when ADDER_IN_REG_EN is defined.
// Backpressure: none; enable toggled randomly, async reset dropped mid-cycle.
module tb_adder4b_reg;

  localparam int W = 4;
`ifdef ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W:0]   Sum;
  logic         sum_valid;
  logic         carry;
  logic         zero;
  logic         s_ovf;

  int checks = 0;
  int errors = 0;

  adder4b_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .A         (A),
    .B         (B),
    .Sum       (Sum),
    .sum_valid (sum_valid),
    .carry     (carry),
    .zero      (zero),
    .s_ovf     (s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: operations queued for LAT-1 edges, then applied with integer arithmetic.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         en;
  } op_t;

  op_t pipe[$];
  int  m_sum;
  bit  m_vld;
  bit  m_ovf;

  function automatic int as_signed(input int v);
    return (v >= (1 << (W-1))) ? v - (1 << W) : v;
  endfunction

  task automatic model_reset();
    op_t z;
    z = '0;
    m_sum = 0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
    pipe.delete();
    repeat (LAT-1) pipe.push_back(z);
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    int  ss;
    if (!r) begin
      model_reset();
    end else begin
      o.a = a; o.b = b; o.en = en;
      pipe.push_back(o);
      o = pipe.pop_front();
      m_vld = o.en;
      if (o.en) begin
        m_sum = int'(o.a) + int'(o.b);
        ss    = as_signed(int'(o.a)) + as_signed(int'(o.b));
        m_ovf = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
      end
    end
  endtask

  task automatic compare_model();
    chk("rnd_sum",   32'(Sum),       32'(m_sum));
    chk("rnd_vld",   32'(sum_valid), 32'(m_vld));
    chk("rnd_carry", 32'(carry),     32'(m_sum >> W));
    chk("rnd_zero",  32'(zero),      32'(m_sum == 0));
    chk("rnd_ovf",   32'(s_ovf),     32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a; B = b; enable = 1'b1;
    repeat (LAT) step();
  endtask

  initial begin
    logic          c_rst, c_en;
    logic [W-1:0]  c_a, c_b;

    rst = 1'b1; enable = 1'b0; A = '0; B = '0;
    #3 rst = 1'b0;
    #1;
    chk("rst_async_sum",  32'(Sum),  32'd0);
    chk("rst_async_zero", 32'(zero), 32'd1);

    // Clocks under reset with live operands must not load.
    A = 3; B = 3; enable = 1'b1;
    repeat (3) step();
    chk("rst_sum",   32'(Sum),       32'd0);
    chk("rst_zero",  32'(zero),      32'd1);
    chk("rst_vld",   32'(sum_valid), 32'd0);
    chk("rst_carry", 32'(carry),     32'd0);
    chk("rst_ovf",   32'(s_ovf),     32'd0);

    rst = 1'b1;
    load(4'd3, 4'd3);
    chk("add_sum",   32'(Sum),       32'd6);
    chk("add_carry", 32'(carry),     32'd0);
    chk("add_zero",  32'(zero),      32'd0);
    chk("add_vld",   32'(sum_valid), 32'd1);

    load(4'd15, 4'd15);
    chk("max_sum",   32'(Sum),   32'd30);
    chk("max_carry", 32'(carry), 32'd1);
    chk("max_ovf",   32'(s_ovf), 32'd0);

    load(4'd8, 4'd8);
    chk("neg_sum",   32'(Sum),   32'd16);
    chk("neg_carry", 32'(carry), 32'd1);
    chk("neg_ovf",   32'(s_ovf), 32'd1);

    load(4'd3, 4'd3);
    enable = 1'b0; A = 15; B = 15;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_sum", 32'(Sum), 32'd6);
    end
    chk("hold_vld", 32'(sum_valid), 32'd0);
    load(4'd15, 4'd15);
    chk("reen_sum", 32'(Sum), 32'd30);

    // Reset mid-cycle, well away from any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_sum",  32'(Sum),       32'd0);
    chk("mid_rst_zero", 32'(zero),      32'd1);
    chk("mid_rst_vld",  32'(sum_valid), 32'd0);
    rst = 1'b1;

    load(4'd0, 4'd0);
    chk("zero_sum",  32'(Sum),       32'd0);
    chk("zero_flag", 32'(zero),      32'd1);
    chk("zero_vld",  32'(sum_valid), 32'd1);

    // Randomized traffic from a clean reset.
    #1 rst = 1'b0;
    model_reset();
    #1 compare_model();
    for (int i = 0; i < 500; i++) begin
      if (rst && $urandom_range(0, 15) == 0) begin
        #1 rst = 1'b0;
        model_reset();
        #1 compare_model();
      end else if (!rst) begin
        rst = 1'($urandom_range(0, 1));
      end
      A      = W'($urandom);
      B      = W'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      c_rst = rst; c_en = enable; c_a = A; c_b = B;
      @(posedge clk);
      model_edge(c_rst, c_en, c_a, c_b);
      #1 compare_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
